// File: rtl/keypad_entry.sv
// keypad_entry
//   Turns the raw keypad decoder output into debounced key presses and
//   assembles DIGITS decimal digits into a code word for the lock stage.
//   Each accepted press gives one key_strobe. A completed code gives one
//   code_valid pulse. A partial entry is dropped by the idle timer (with a
//   timeout pulse) or by clear.
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   reset        in   synchronous, active-high
//   valid        in   decoder: some key is down
//   number       in   decoder: key value, 0-9 meaningful
//   clear        in   abandon the partial entry on the next edge
//   key_strobe   out  one-cycle pulse per accepted press
//   key_digit    out  value of the last accepted press, held between strobes
//   digit_count  out  digits collected in the current entry
//   code         out  last completed code, first digit in the top nibble
//   code_valid   out  one-cycle pulse when code updates
//   timeout      out  one-cycle pulse when the idle timer drops an entry
module keypad_entry #(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid,
  input  logic [3:0]                   number,
  input  logic                         clear,
  output logic                         key_strobe,
  output logic [3:0]                   key_digit,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic [4*DIGITS-1:0]          code,
  output logic                         code_valid,
  output logic                         timeout
);

  localparam int CW    = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [CW-1:0]    DC_LAST  = CW'(DIGITS - 1);
  localparam logic [CW-1:0]    DC_FULL  = CW'(DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_UP,
    S_PRESS_WAIT,
    S_DOWN,
    S_RELEASE_WAIT
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_latch;
  logic [4*DIGITS-1:0] r_entry;
  logic [TMR_W-1:0]   r_timer;

  state_t             w_state_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [3:0]         w_latch_nx;
  logic               w_accept;
  logic               w_cand_vld;
  logic [4*DIGITS+3:0] w_wide;
  logic [4*DIGITS-1:0] w_shift;

  // A ghosted multi-key code (number > 9) is treated exactly like no key.
  assign w_cand_vld = valid && (number <= 4'd9);

  // Shift the new digit in at the bottom; written via a wide concatenation
  // so that DIGITS == 1 needs no special case.
  assign w_wide  = {r_entry, r_latch};
  assign w_shift = w_wide[4*DIGITS-1:0];

  // Debounce FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_UP;
      r_cnt   <= '0;
      r_latch <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_latch <= w_latch_nx;
    end
  end

  // Debounce FSM: next state. r_cnt holds the number of matching samples
  // seen so far, so the DEBOUNCE-th match is the one that sees CNT_LAST.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_latch_nx = r_latch;
    w_accept   = 1'b0;
    case (r_state)
      S_UP: begin
        if (w_cand_vld) begin
          w_state_nx = S_PRESS_WAIT;
          w_latch_nx = number;
          w_cnt_nx   = CNT_ONE;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_cand_vld) begin
          w_state_nx = S_UP;
        end else if (number == r_latch) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nx = S_DOWN;
            w_accept   = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end else begin
          // A different digit restarts the count on the new value.
          w_latch_nx = number;
          w_cnt_nx   = CNT_ONE;
        end
      end
      S_DOWN: begin
        if (!w_cand_vld) begin
          w_state_nx = S_RELEASE_WAIT;
          w_cnt_nx   = CNT_ONE;
        end
      end
      S_RELEASE_WAIT: begin
        // Any key during the release window is a bounce of the held key.
        if (w_cand_vld) begin
          w_state_nx = S_DOWN;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = S_UP;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_UP;
      end
    endcase
  end

  // Entry assembly, idle timer and output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      key_strobe  <= 1'b0;
      key_digit   <= '0;
      digit_count <= '0;
      code        <= '0;
      code_valid  <= 1'b0;
      timeout     <= 1'b0;
      r_entry     <= '0;
      r_timer     <= '0;
    end else begin
      key_strobe <= w_accept;
      code_valid <= 1'b0;
      timeout    <= 1'b0;
      if (w_accept) begin
        key_digit <= r_latch;
      end

      // clear outranks a new digit; a new digit outranks timer expiry.
      if (clear) begin
        r_entry     <= '0;
        digit_count <= '0;
        r_timer     <= '0;
      end else if (w_accept) begin
        r_entry     <= w_shift;
        digit_count <= digit_count + 1'b1;
        r_timer     <= '0;
        if (digit_count == DC_LAST) begin
          code       <= w_shift;
          code_valid <= 1'b1;
        end
      end else if (digit_count == DC_FULL) begin
        // Completed entry is shown for one cycle, then restarts.
        r_entry     <= '0;
        digit_count <= '0;
        r_timer     <= '0;
      end else if (digit_count != '0) begin
        if (r_timer == TMR_LAST) begin
          r_entry     <= '0;
          digit_count <= '0;
          r_timer     <= '0;
          timeout     <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [3:0]  number;
  logic        clear;
  logic        key_strobe;
  logic [3:0]  key_digit;
  logic [2:0]  digit_count;
  logic [15:0] code;
  logic        code_valid;
  logic        timeout;

  int n_vec  = 0;
  int n_miss = 0;
  int n_strobe = 0;
  int n_cv     = 0;
  int n_to     = 0;

  // snapshots taken on the cycle key_strobe is high, and the cycle after
  logic        s_cv;
  logic [15:0] s_code;
  logic [2:0]  s_dc;
  logic [3:0]  s_kd;
  logic [2:0]  s_dc_next;

  keypad_entry #(.DIGITS(4), .DEBOUNCE(4), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .valid(valid), .number(number), .clear(clear),
    .key_strobe(key_strobe), .key_digit(key_digit), .digit_count(digit_count),
    .code(code), .code_valid(code_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_strobe) n_strobe++;
    if (code_valid) n_cv++;
    if (timeout)    n_to++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold digit d for 'hold' cycles (clear asserted on edge clr_tick, 0 = never),
  // then release for 'rel' cycles.
  task automatic press(input logic [3:0] d, input int hold, input int rel, input int clr_tick);
    logic prev;
    prev = 1'b0;
    valid  = 1'b1;
    number = d;
    for (int i = 1; i <= hold + rel; i++) begin
      if (i == hold + 1) begin
        valid  = 1'b0;
        number = 4'd0;
      end
      clear = (i == clr_tick);
      tick();
      clear = 1'b0;
      if (prev) s_dc_next = digit_count;
      if (key_strobe) begin
        s_cv   = code_valid;
        s_code = code;
        s_dc   = digit_count;
        s_kd   = key_digit;
      end
      prev = key_strobe;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int s0;
    int s_cv0;
    int s_to0;
    int k;
    logic found;
    logic bnc [5];

    reset = 1'b1; valid = 1'b0; number = 4'd0; clear = 1'b0;
    tick();
    tick();
    check("rst_strobe", key_strobe, 0);
    check("rst_digit", key_digit, 0);
    check("rst_count", digit_count, 0);
    check("rst_code", code, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    n_strobe = 0; n_cv = 0; n_to = 0;

    // Steady press of 2 for 10 cycles
    s0 = n_strobe;
    valid = 1'b1; number = 4'd2;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) check("t1_no_early_strobe", key_strobe, 0);
      if (i == 4) begin
        check("t1_strobe", key_strobe, 1);
        check("t1_key_digit", key_digit, 2);
        check("t1_count", digit_count, 1);
      end
      if (i == 5) check("t1_strobe_one_cycle", key_strobe, 0);
    end
    check("t1_strobe_total", n_strobe - s0, 1);
    valid = 1'b0; number = 4'd0;
    for (int i = 0; i < 6; i++) tick();
    do_clear();
    check("t1_clear_count", digit_count, 0);
    check("t1_clear_keeps_digit", key_digit, 2);

    // Bounce 1,0,1,1,0 then steady
    s0 = n_strobe;
    bnc[0] = 1'b1; bnc[1] = 1'b0; bnc[2] = 1'b1; bnc[3] = 1'b1; bnc[4] = 1'b0;
    number = 4'd3;
    for (int i = 0; i < 5; i++) begin
      valid = bnc[i];
      tick();
    end
    check("t2_bounce_no_strobe", n_strobe - s0, 0);
    valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) check("t2_steady3_no_strobe", n_strobe - s0, 0);
      if (i == 4) check("t2_steady4_strobe", key_strobe, 1);
    end
    check("t2_strobe_total", n_strobe - s0, 1);
    valid = 1'b0; number = 4'd0;
    for (int i = 0; i < 6; i++) tick();
    check("t2_count", digit_count, 1);
    check("t2_key_digit", key_digit, 3);
    do_clear();

    // Full code 1,2,3,4 then a fifth digit
    s_cv0 = n_cv;
    press(4'd1, 6, 6, 0);
    press(4'd2, 6, 6, 0);
    press(4'd3, 6, 6, 0);
    check("t3_count3", digit_count, 3);
    press(4'd4, 6, 6, 0);
    check("t3_code_valid", s_cv, 1);
    check("t3_code", s_code, 16'h1234);
    check("t3_count_full", s_dc, 4);
    check("t3_count_next", s_dc_next, 0);
    check("t3_cv_pulses", n_cv - s_cv0, 1);
    press(4'd5, 6, 6, 0);
    check("t3_fifth_count", s_dc, 1);
    check("t3_fifth_no_cv", s_cv, 0);
    check("t3_fifth_code_held", code, 16'h1234);
    do_clear();

    // Idle timeout after a single digit
    s_cv0 = n_cv;
    s_to0 = n_to;
    press(4'd7, 6, 6, 0);
    check("t4_count1", s_dc, 1);
    k = 0; found = 1'b0;
    while (!found && k < 1100) begin
      tick();
      k++;
      if (timeout) found = 1'b1;
    end
    check("t4_timeout_seen", found, 1);
    check("t4_timeout_cycle", k, 992);
    check("t4_count_zero", digit_count, 0);
    check("t4_no_code_valid", n_cv - s_cv0, 0);
    check("t4_code_held", code, 16'h1234);
    check("t4_one_timeout", n_to - s_to0, 1);

    // Digit strobe landing on the expiry edge wins over the timeout
    s_to0 = n_to;
    press(4'd7, 6, 6, 0);
    for (int i = 0; i < 988; i++) tick();
    valid = 1'b1; number = 4'd8;
    for (int i = 0; i < 4; i++) tick();
    check("t4b_strobe", key_strobe, 1);
    check("t4b_no_timeout", timeout, 0);
    check("t4b_count2", digit_count, 2);
    tick();
    tick();
    valid = 1'b0; number = 4'd0;
    for (int i = 0; i < 6; i++) tick();
    check("t4b_no_timeout_total", n_to - s_to0, 0);
    do_clear();

    // clear on the completing strobe
    s_cv0 = n_cv;
    press(4'd5, 6, 6, 0);
    press(4'd6, 6, 6, 0);
    press(4'd9, 6, 6, 0);
    press(4'd0, 6, 6, 4);
    check("t5_key_digit", s_kd, 0);
    check("t5_count_zero", s_dc, 0);
    check("t5_no_cv", s_cv, 0);
    check("t5_code_held", s_code, 16'h1234);
    check("t5_cv_total", n_cv - s_cv0, 0);
    check("t5_count_after", digit_count, 0);

    // Ghosted key, then a short release bounce while held
    s0 = n_strobe;
    valid = 1'b1; number = 4'hF;
    for (int i = 0; i < 10; i++) tick();
    check("t6_ghost_no_strobe", n_strobe - s0, 0);
    valid = 1'b0; number = 4'd0;
    for (int i = 0; i < 6; i++) tick();
    valid = 1'b1; number = 4'd8;
    for (int i = 0; i < 6; i++) tick();
    valid = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    valid = 1'b0; number = 4'd0;
    for (int i = 0; i < 6; i++) tick();
    check("t6_one_strobe", n_strobe - s0, 1);
    check("t6_count", digit_count, 1);
    check("t6_key_digit", key_digit, 8);

    // Reset in the middle of a held key
    valid = 1'b1; number = 4'd9;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t7_rst_count", digit_count, 0);
    check("t7_rst_code", code, 0);
    check("t7_rst_digit", key_digit, 0);
    reset = 1'b0;
    s0 = n_strobe;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) check("t7_no_early", key_strobe, 0);
      if (i == 4) check("t7_strobe", key_strobe, 1);
    end
    check("t7_one_strobe", n_strobe - s0, 1);
    check("t7_key_digit", key_digit, 9);
    check("t7_count", digit_count, 1);
    valid = 1'b0; number = 4'd0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
